// File: rtl/mips_pkg.sv
// Shared constants and types for the pipelined MIPS datapath.
// Imported by the fetch stage and its PC register.
package mips_pkg;

    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD        = 32'h1000_FFFF;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter flop with next-PC selection.
// Redirect targets are forced to word alignment.
module pc_register
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    logic [31:0] pc_next;

    assign pc_plus4 = pc + 32'd4;

    // Next PC: freeze when halted, redirect beats stall, else sequential.
    always_comb begin
        pc_next = pc;
        if (hold) begin
            pc_next = pc;
        end else if (redirect_valid) begin
            pc_next = word_align(redirect_pc);
        end else if (stall) begin
            pc_next = pc;
        end else begin
            pc_next = pc_plus4;
        end
    end

    // PC state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: PC, ROM address, IF/ID register, halt detection.
// Redirect and flush insert a bubble; halt word freezes fetch.
module instruction_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] Address,
    input  logic [31:0] Instruction,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        halted,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        kill;
    logic        capture;
    if_id_t      if_id_q;

    pc_register #(
        .RESET_PC(RESET_PC)
    ) u_pc (
        .clk           (clk),
        .reset         (reset),
        .hold          (halted),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .pc            (pc),
        .pc_plus4      (pc_plus4)
    );

    assign Address = pc;
    assign kill    = !halted && (flush || redirect_valid);
    assign capture = !halted && !flush && !redirect_valid && !stall;

    // IF/ID register: bubble on kill, load on capture, else hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_id_q <= '{instr: NOP_WORD, pc_plus4: 32'd0, valid: 1'b0};
        end else if (kill) begin
            if_id_q.instr <= NOP_WORD;
            if_id_q.valid <= 1'b0;
        end else if (capture) begin
            if_id_q <= '{instr: Instruction, pc_plus4: pc_plus4, valid: 1'b1};
        end
    end

    // Fetch counter and halt flag advance only on real captures.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_count <= 32'd0;
            halted      <= 1'b0;
        end else if (capture) begin
            fetch_count <= fetch_count + 32'd1;
            if (Instruction == HALT_WORD) begin
                halted <= 1'b1;
            end
        end
    end

    // Sticky flag for any misaligned redirect target, even when halted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_err <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            misalign_err <= 1'b1;
        end
    end

    assign if_id_instr    = if_id_q.instr;
    assign if_id_pc_plus4 = if_id_q.pc_plus4;
    assign if_id_valid    = if_id_q.valid;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: ROM array, reference model,
// per-cycle compare plus directed literal checks.
module tb_instruction_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] Address;
    logic [31:0] Instruction;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        halted;
    logic        misalign_err;
    logic [31:0] fetch_count;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] rom [0:63];

    instruction_fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .Address       (Address),
        .Instruction   (Instruction),
        .if_id_instr   (if_id_instr),
        .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_valid   (if_id_valid),
        .halted        (halted),
        .misalign_err  (misalign_err),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a < 32'd256) return rom[a[7:2]];
        return 32'h0000_0000;
    endfunction

    assign Instruction = rom_word(Address);

    // Reference model state.
    logic [31:0] m_pc = 32'd0;
    logic [31:0] m_instr = 32'd0;
    logic [31:0] m_pc4 = 32'd0;
    logic        m_valid = 1'b0;
    logic        m_halt = 1'b0;
    logic        m_mis = 1'b0;
    logic [31:0] m_cnt = 32'd0;

    always @(negedge reset) begin
        m_pc = 32'd0; m_instr = 32'd0; m_pc4 = 32'd0;
        m_valid = 1'b0; m_halt = 1'b0; m_mis = 1'b0; m_cnt = 32'd0;
    end

    always @(posedge clk) begin
        logic [31:0] fetched;
        if (reset) begin
            if (redirect_valid && redirect_pc[1:0] != 2'b00) m_mis = 1'b1;
            if (!m_halt) begin
                fetched = rom_word(m_pc);
                if (redirect_valid || flush) begin
                    m_instr = 32'd0;
                    m_valid = 1'b0;
                end else if (!stall) begin
                    m_instr = fetched;
                    m_pc4 = m_pc + 32'd4;
                    m_valid = 1'b1;
                    m_cnt = m_cnt + 1;
                    if (fetched == 32'h1000_FFFF) m_halt = 1'b1;
                end
                if (redirect_valid) m_pc = {redirect_pc[31:2], 2'b00};
                else if (!stall) m_pc = m_pc + 32'd4;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        check("cmp_address", Address, m_pc);
        check("cmp_instr", if_id_instr, m_instr);
        check("cmp_pc4", if_id_pc_plus4, m_pc4);
        check("cmp_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
        check("cmp_halted", {31'd0, halted}, {31'd0, m_halt});
        check("cmp_misalign", {31'd0, misalign_err}, {31'd0, m_mis});
        check("cmp_count", fetch_count, m_cnt);
    end

    task automatic step(input logic st, input logic fl, input logic rv,
                        input logic [31:0] rp);
        stall = st; flush = fl; redirect_valid = rv; redirect_pc = rp;
        @(negedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'h2000_0000 | i;
        rom[0] = 32'h2004_0005;
        rom[1] = 32'h2005_0007;
        rom[2] = 32'h0085_3020;
        rom[3] = 32'h1000_FFFF;
        rom[4] = 32'h2006_0009;

        #1 reset = 1'b0;
        #1;
        check("rst_address", Address, 32'h0);
        check("rst_valid", {31'd0, if_id_valid}, 32'd0);
        check("rst_count", fetch_count, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;

        step(0, 0, 0, 0);
        check("e1_address", Address, 32'h4);
        check("e1_instr", if_id_instr, 32'h2004_0005);
        check("e1_pc4", if_id_pc_plus4, 32'h4);
        check("e1_count", fetch_count, 32'd1);
        step(0, 0, 0, 0);
        check("e2_address", Address, 32'h8);

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("stall_address", Address, 32'h8);
        check("stall_instr", if_id_instr, 32'h2005_0007);
        check("stall_count", fetch_count, 32'd2);
        step(0, 0, 0, 0);
        check("unstall_address", Address, 32'hC);

        step(0, 0, 1, 32'h10);
        check("redir_address", Address, 32'h10);
        check("redir_valid", {31'd0, if_id_valid}, 32'd0);
        check("redir_instr", if_id_instr, 32'h0);
        check("redir_count", fetch_count, 32'd3);

        step(1, 0, 1, 32'h13);
        check("mis_address", Address, 32'h10);
        check("mis_flag", {31'd0, misalign_err}, 32'd1);
        step(0, 0, 0, 0);
        check("mis_sticky", {31'd0, misalign_err}, 32'd1);
        check("mis_after_instr", if_id_instr, 32'h2006_0009);

        step(0, 1, 0, 0);
        check("flush_address", Address, 32'h18);
        check("flush_valid", {31'd0, if_id_valid}, 32'd0);

        step(0, 0, 1, 32'hFFFF_FFFC);
        check("wrap_target", Address, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        check("wrap_address", Address, 32'h0);
        check("wrap_pc4", if_id_pc_plus4, 32'h0);

        step(0, 0, 1, 32'hC);
        step(0, 0, 0, 0);
        check("halt_flag", {31'd0, halted}, 32'd1);
        check("halt_address", Address, 32'h10);
        check("halt_instr", if_id_instr, 32'h1000_FFFF);
        check("halt_count", fetch_count, 32'd6);
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h20);
        check("halt_hold_addr", Address, 32'h10);
        check("halt_hold_count", fetch_count, 32'd6);

        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_address", Address, 32'h0);
        check("midrst_halted", {31'd0, halted}, 32'd0);
        check("midrst_mis", {31'd0, misalign_err}, 32'd0);
        check("midrst_count", fetch_count, 32'd0);
        check("midrst_instr", if_id_instr, 32'h0);
        @(negedge clk);
        #1 reset = 1'b1;
        step(0, 0, 0, 0);
        check("resume_address", Address, 32'h4);
        check("resume_instr", if_id_instr, 32'h2004_0005);
        check("resume_count", fetch_count, 32'd1);
        step(0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Fetch stage feeding the combinational instruction ROM: owns the program counter, drives the ROM `Address`, captures the returned `Instruction` into an IF/ID pipeline register, and accepts stall, flush and redirect (branch/jump/jr) requests from later stages. It also detects the program's terminal self-loop (`beq $zero,$zero,-1`) and freezes fetch. It sits between the control/hazard logic and the decode stage of the pipelined datapath.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- stall  in  1  hold PC and IF/ID register this cycle
- flush  in  1  load bubble (NOP, valid=0) into IF/ID this cycle
- redirect_valid  in  1  PC redirect request from execute (taken branch, j, jal, jr)
- redirect_pc  in  32  redirect target byte address
- Address  out  32  ROM word address, equals current PC (combinational from PC register)
- Instruction  in  32  ROM read data for `Address`, same cycle
- if_id_instr  out  32  captured instruction
- if_id_pc_plus4  out  32  PC+4 of captured instruction
- if_id_valid  out  1  IF/ID holds a real instruction
- halted  out  1  sticky: halt word captured, fetch frozen
- misalign_err  out  1  sticky: redirect target had nonzero bits [1:0]
- fetch_count  out  32  number of valid instructions captured into IF/ID

## Operation
- PC update per edge, priority high to low: halted → hold; redirect_valid → {redirect_pc[31:2],2'b00}; stall → hold; else PC+4.
- PC+4 arithmetic 32-bit, wraps modulo 2^32 (0xFFFF_FFFC → 0x0000_0000).
- IF/ID update per edge, priority: halted → hold; flush or redirect_valid → instr=32'h0000_0000, valid=0, pc_plus4 unchanged; stall → hold; else instr=Instruction, pc_plus4=PC+4, valid=1.
- Redirect always kills the wrong-path instruction currently at `Address`; flush without redirect kills it but PC still advances (unless stall).
- redirect_valid with stall: redirect wins for both PC and IF/ID.
- fetch_count increments by 1 on each edge where IF/ID loads with valid=1; wraps at 2^32.
- halted sets on the edge where IF/ID loads Instruction==32'h1000_FFFF with valid=1; the halt instruction itself is captured and counted; afterwards PC, IF/ID, fetch_count hold until reset.
- misalign_err sets on any edge with redirect_valid=1 and redirect_pc[1:0]!=0; sticky until reset.

## Timing
- Reset (asynchronous, on reset low): PC=RESET_PC, if_id_instr=0, if_id_pc_plus4=0, if_id_valid=0, halted=0, misalign_err=0, fetch_count=0; takes effect immediately, mid-operation included; Address follows PC.
- First edge after reset deasserts: IF/ID captures word at RESET_PC.
- Fetch-to-decode latency 1 cycle; redirect penalty 1 bubble.
- stall/flush/redirect sampled at the same edge they are to affect; no internal buffering.
- Instruction assumed valid combinationally within the cycle (zero-latency ROM).

## Structure
- Shared package `mips_pkg`: NOP_WORD=32'h0000_0000, HALT_WORD=32'h1000_FFFF, default RESET_PC, opcode constants.
- One sub-module: `pc_register` (PC flop with RESET_PC, next-PC mux, alignment masking); IF/ID register, counter and sticky flags in the top.

## Test plan
- Reset release, no stall, ROM with addi at 0 (0x2004_0005): Address 0,4,8 on successive cycles; after edge 1 if_id_instr=0x2004_0005, pc_plus4=4, valid=1, fetch_count=1.
- stall high 2 cycles while Address=8: Address stays 8, IF/ID and fetch_count unchanged; on release Address=0xC next edge.
- redirect_valid=1, redirect_pc=0x10 while Address=0xC: next Address=0x10, if_id_valid=0, if_id_instr=0, fetch_count unchanged.
- redirect_valid=1 with stall=1, redirect_pc=0x13: Address=0x10, misalign_err=1 and stays 1 after redirect drops.
- ROM returns 0x1000_FFFF at Address 0xC: after that edge halted=1, Address=0x10 thereafter, if_id_instr=0x1000_FFFF held, fetch_count frozen.
- reset pulsed low mid-cycle while halted: all outputs return to reset values before next edge; fetch resumes from RESET_PC.
